// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with HI/LO result registers writable through MTHI/MTLO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mult_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic             by_zero;

  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    // Multiply: acc:shr holds the running product, shr low bit is the next multiplier bit.
    mult_sum = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: acc is the partial remainder, shr shifts dividend bits out and quotient bits in.
    div_shift = {acc_q, shr_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[WIDTH];

    prod_raw = {acc_q, shr_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod_raw : prod_raw;
    by_zero  = is_div_q && (opnd_q == '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    shr_d    = shr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_a_d  = a_neg;
          neg_b_d  = b_neg;
          a_d      = a;
          acc_d    = '0;
          opnd_d   = op[1] ? b_mag : a_mag;
          shr_d    = op[1] ? a_mag : b_mag;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = by_zero;
          if (by_zero) begin
            hi_d = a_q;
            lo_d = '1;
          end else if (is_div_q) begin
            lo_d = (neg_a_q ^ neg_b_q) ? -shr_q : shr_q;
            hi_d = neg_a_q ? -acc_q : acc_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            acc_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            shr_d = {shr_q[WIDTH-2:0], div_ok};
          end else begin
            acc_d = mult_sum[WIDTH:1];
            shr_d = {mult_sum[0], shr_q[WIDTH-1:1]};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      shr_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      shr_q    <= shr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed MULT/DIV results, latency,
// busy-time start/write suppression, back-to-back issue and mid-run reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        wr_hi = 1'b0, wr_lo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int dones;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive start for exactly one rising edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    issue(o, x, y);
    check({tag, " busy"}, {63'd0, busy}, 64'd1);
    wait_done(cyc);
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check({tag, " dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d cycles=%0d",
             o, x, y, hi, lo, div_by_zero, cyc);
  endtask

  initial begin
    #2;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset dbz", {63'd0, div_by_zero}, 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("multu 7*6", MULTU, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0);
    @(negedge clk);
    check("done pulse width", {63'd0, done}, 64'd0);
    check("idle busy", {63'd0, busy}, 64'd0);

    run_op("multu max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult -3*5", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("mult -1*-1", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
    run_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0);
    run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu 100/0", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1);
    run_op("div -5/0", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

    // start mid-RUN is ignored; then back-to-back issue in the done cycle
    issue(MULTU, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    op = DIVU; a = 32'd9; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("ignored start latency", 64'(cyc + 6), 64'd33);
    check("ignored start lo", {32'd0, lo}, 64'd12);
    $display("mid-run start ignored: lo=%h cycles=%0d", lo, cyc + 6);
    op = MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b busy", {63'd0, busy}, 64'd1);
    wait_done(cyc);
    check("b2b latency", 64'(cyc), 64'd33);
    check("b2b lo", {32'd0, lo}, 64'd25);
    $display("back-to-back multu 5*5: lo=%h cycles=%0d", lo, cyc);

    // write in the done cycle lands after the result
    wr_lo = 1'b1; wdata = 32'hCAFE0001;
    @(negedge clk);
    wr_lo = 1'b0;
    check("done-cycle wr_lo", {32'd0, lo}, 64'hCAFE0001);
    $display("done-cycle write: lo=%h", lo);

    // MTHI while busy is dropped and hi holds through RUN
    issue(MULTU, 32'd2, 32'd3);
    wr_hi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0;
    check("busy wr_hi dropped", {32'd0, hi}, 64'd0);
    check("lo held in run", {32'd0, lo}, 64'hCAFE0001);
    wait_done(cyc);
    check("after drop lo", {32'd0, lo}, 64'd6);
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0;
    check("idle wr_hi", {32'd0, hi}, 64'h1234);
    $display("wr_hi busy dropped, idle hi=%h", hi);

    // write in the start cycle is applied, then overwritten by the result
    @(negedge clk);
    op = MULTU; a = 32'd1; b = 32'd1; start = 1'b1; wr_lo = 1'b1; wdata = 32'h55;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    check("start-cycle wr_lo", {32'd0, lo}, 64'h55);
    wait_done(cyc);
    check("start-cycle overwrite", {hi, lo}, 64'h1);
    $display("start-cycle write then result: hi=%h lo=%h", hi, lo);

    // reset in the middle of a MULT aborts without a result
    issue(MULT, 32'hFFFFFFFD, 32'd5);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    check("abort hilo after", {hi, lo}, 64'd0);
    $display("reset abort: busy=%0d hi=%h lo=%h dones=%0d", busy, hi, lo, dones);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
